// File: rtl/mem150_cache_subsystem.sv
// mem150_cache_subsystem: direct-mapped write-through D$ and I$ sharing one line-fill memory port
// Optional feature: define CACHE_STATS_EN to add dcache_hit_cnt / dcache_miss_cnt read counters.
// Ports:
//   cpu_clk_g, rst_n            clock, asynchronous active-low reset
//   init_done                   high once both valid arrays have been cleared
//   dcache_* / icache_*         CPU requests (addr, re, byte we, din) and read data (dcache_dout, instruction)
//   stall                       CPU holds all inputs while high
//   mem_req_*                   valid/ready request: line read (rnw=1) or masked word write (rnw=0)
//   mem_resp_valid/_data        single-beat 128-bit line fill
module mem150_cache_subsystem #(
   parameter int INDEX_BITS = 8,
   parameter int LINE_WORDS = 4
) (
   input  logic                      cpu_clk_g,
   input  logic                      rst_n,
   output logic                      init_done,
`ifdef CACHE_STATS_EN
   output logic [31:0]               dcache_hit_cnt,
   output logic [31:0]               dcache_miss_cnt,
`endif
   input  logic [31:0]               dcache_addr,
   input  logic                      dcache_re,
   input  logic [3:0]                dcache_we,
   input  logic [31:0]               dcache_din,
   output logic [31:0]               dcache_dout,
   input  logic [31:0]               icache_addr,
   input  logic                      icache_re,
   input  logic [3:0]                icache_we,
   input  logic [31:0]               icache_din,
   output logic [31:0]               instruction,
   output logic                      stall,
   output logic                      mem_req_valid,
   input  logic                      mem_req_ready,
   output logic                      mem_req_rnw,
   output logic [31:0]               mem_req_addr,
   output logic [31:0]               mem_req_wdata,
   output logic [3:0]                mem_req_wmask,
   input  logic                      mem_resp_valid,
   input  logic [32*LINE_WORDS-1:0]  mem_resp_data
);
   localparam int NL = 2 ** INDEX_BITS;
   localparam int TB = 28 - INDEX_BITS;
   localparam int LB = 32 * LINE_WORDS;

   typedef enum logic [1:0] {S_INIT, S_IDLE, S_REQ, S_RESP} state_t;

   state_t                  state;
   logic [INDEX_BITS-1:0]   init_cnt;
   logic                    own;
   logic                    sel;
   logic                    accept;
   logic [1:0][31:0]        in_addr, in_din, req_addr, req_din, dout_c;
   logic [1:0][3:0]         in_we, req_we;
   logic [1:0]              in_re, need, pend_wr;

   assign in_addr = {icache_addr, dcache_addr};
   assign in_din  = {icache_din, dcache_din};
   assign in_we   = {icache_we, dcache_we};
   assign in_re   = {icache_re, dcache_re};

   // stall is combinational so a miss or write holds the CPU in its compare cycle
   assign stall       = (state != S_IDLE) | (|need);
   assign accept      = ~stall;
   assign sel         = ~need[0];
   assign dcache_dout = dout_c[0];
   assign instruction = dout_c[1];

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] m);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = m[i] ? n[8*i +: 8] : o[8*i +: 8];
      return r;
   endfunction

   // index 0 is the D$, index 1 the I$; both are otherwise identical
   for (genvar c = 0; c < 2; c++) begin : g_c
      logic [31:0]            a, d, q, wd;
      logic [3:0]             w;
      logic                   rp, wp, h, f, wa;
      logic [NL-1:0]          vld;
      logic [TB-1:0]          tag_mem [NL];
      logic [LB-1:0]          dat_mem [NL];
      logic [INDEX_BITS-1:0]  idx;
      logic [1:0]             off;
      assign idx = a[INDEX_BITS+3:4];
      assign off = a[3:2];
      assign wd  = dat_mem[idx][{off, 5'b0} +: 32];
      assign h   = vld[idx] & (tag_mem[idx] == a[31:INDEX_BITS+4]);
      assign f   = (state == S_RESP) & mem_resp_valid & (own == 1'(c));
      assign wa  = (state == S_REQ) & mem_req_ready & ~mem_req_rnw & (own == 1'(c));
      assign need[c]     = wp | (rp & ~h);
      assign pend_wr[c]  = wp;
      assign req_addr[c] = wp ? (a & ~32'h3) : (a & ~32'hF);
      assign req_din[c]  = d;
      assign req_we[c]   = w;
      assign dout_c[c]   = (rp & h) ? wd : q;
      always_ff @(posedge cpu_clk_g or negedge rst_n) begin
         if (!rst_n) begin
            a   <= '0;
            d   <= '0;
            w   <= '0;
            rp  <= 1'b0;
            wp  <= 1'b0;
            q   <= '0;
            vld <= '0;
         end else begin
            if (accept) begin
               a  <= in_addr[c];
               d  <= in_din[c];
               w  <= in_we[c];
               rp <= in_re[c] & ~|in_we[c];
               wp <= |in_we[c];
            end else begin
               if (f | (rp & h)) rp <= 1'b0;
               if (wa) wp <= 1'b0;
            end
            // read data is latched so the output holds once the read retires
            if (rp & h) q <= wd;
            else if (f) q <= mem_resp_data[{off, 5'b0} +: 32];
            if (state == S_INIT) vld[init_cnt] <= 1'b0;
            else if (f) vld[idx] <= 1'b1;
         end
      end
      always_ff @(posedge cpu_clk_g) begin
         if (f) begin
            dat_mem[idx] <= mem_resp_data;
            tag_mem[idx] <= a[31:INDEX_BITS+4];
         end else if (wa & h) dat_mem[idx][{off, 5'b0} +: 32] <= merge(wd, d, w);
      end
   end

   always_ff @(posedge cpu_clk_g or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_INIT;
         init_cnt      <= '0;
         init_done     <= 1'b0;
         own           <= 1'b0;
         mem_req_valid <= 1'b0;
         mem_req_rnw   <= 1'b0;
         mem_req_addr  <= '0;
         mem_req_wdata <= '0;
         mem_req_wmask <= '0;
      end else begin
         case (state)
            S_INIT: begin
               init_cnt <= init_cnt + INDEX_BITS'(1);
               if (&init_cnt) begin
                  state     <= S_IDLE;
                  init_done <= 1'b1;
               end
            end
            // D$ wins whenever it needs the port; sel falls to the I$ only otherwise
            S_IDLE: if (|need) begin
               own           <= sel;
               mem_req_valid <= 1'b1;
               mem_req_rnw   <= ~pend_wr[sel];
               mem_req_addr  <= req_addr[sel];
               mem_req_wdata <= req_din[sel];
               mem_req_wmask <= req_we[sel];
               state         <= S_REQ;
            end
            S_REQ: if (mem_req_ready) begin
               mem_req_valid <= 1'b0;
               state         <= mem_req_rnw ? S_RESP : S_IDLE;
            end
            S_RESP: if (mem_resp_valid) state <= S_IDLE;
            default: state <= S_INIT;
         endcase
      end
   end

`ifdef CACHE_STATS_EN
   always_ff @(posedge cpu_clk_g or negedge rst_n) begin
      if (!rst_n) begin
         dcache_hit_cnt  <= '0;
         dcache_miss_cnt <= '0;
      end else begin
         if (g_c[0].rp & g_c[0].h & ~&dcache_hit_cnt) dcache_hit_cnt <= dcache_hit_cnt + 32'd1;
         if (g_c[0].f & ~&dcache_miss_cnt) dcache_miss_cnt <= dcache_miss_cnt + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_mem150_cache_subsystem.sv
// tb_mem150_cache_subsystem: directed self-checking bench with a behavioural memory responder
module tb_mem150_cache_subsystem;
   logic          cpu_clk_g = 1'b0;
   logic          rst_n = 1'b0;
   logic          init_done, stall;
   logic [31:0]   dcache_addr, dcache_din, dcache_dout;
   logic          dcache_re;
   logic [3:0]    dcache_we;
   logic [31:0]   icache_addr, icache_din, instruction;
   logic          icache_re;
   logic [3:0]    icache_we;
   logic          mem_req_valid, mem_req_ready, mem_req_rnw;
   logic [31:0]   mem_req_addr, mem_req_wdata;
   logic [3:0]    mem_req_wmask;
   logic          mem_resp_valid;
   logic [127:0]  mem_resp_data;
`ifdef CACHE_STATS_EN
   logic [31:0]   dcache_hit_cnt, dcache_miss_cnt;
`endif

   typedef struct packed {
      logic        rnw;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wmask;
   } req_t;

   req_t          log_q[$];
   logic [31:0]   mem [bit [31:0]];
   int            n_chk = 0;
   int            n_fail = 0;
   int            exp_hit = 0;
   int            exp_miss = 0;

   always #5 cpu_clk_g = ~cpu_clk_g;

   mem150_cache_subsystem dut (
      .cpu_clk_g      (cpu_clk_g),
      .rst_n          (rst_n),
      .init_done      (init_done),
`ifdef CACHE_STATS_EN
      .dcache_hit_cnt (dcache_hit_cnt),
      .dcache_miss_cnt(dcache_miss_cnt),
`endif
      .dcache_addr    (dcache_addr),
      .dcache_re      (dcache_re),
      .dcache_we      (dcache_we),
      .dcache_din     (dcache_din),
      .dcache_dout    (dcache_dout),
      .icache_addr    (icache_addr),
      .icache_re      (icache_re),
      .icache_we      (icache_we),
      .icache_din     (icache_din),
      .instruction    (instruction),
      .stall          (stall),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_rnw    (mem_req_rnw),
      .mem_req_addr   (mem_req_addr),
      .mem_req_wdata  (mem_req_wdata),
      .mem_req_wmask  (mem_req_wmask),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_data  (mem_resp_data)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] rd_word(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : 32'h0;
   endfunction

   function automatic logic [127:0] line(input logic [31:0] a);
      logic [127:0] l;
      for (int k = 0; k < 4; k++) l[32*k +: 32] = rd_word({a[31:4], 2'(k), 2'b00});
      return l;
   endfunction

   task automatic mem_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
      logic [31:0] o;
      o = rd_word(a);
      for (int i = 0; i < 4; i++) if (m[i]) o[8*i +: 8] = d[8*i +: 8];
      mem[a] = o;
   endtask

   // memory responder: ready for one cycle per request, fill data three negedges after accept
   initial begin
      int          dly;
      logic [31:0] ra;
      dly = 0;
      ra = '0;
      mem_req_ready = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_data = '0;
      forever begin
         @(negedge cpu_clk_g);
         mem_resp_valid = 1'b0;
         if (!rst_n) begin
            mem_req_ready = 1'b0;
            dly = 0;
         end else begin
            if (dly > 0) begin
               dly--;
               if (dly == 0) begin
                  mem_resp_valid = 1'b1;
                  mem_resp_data = line(ra);
               end
            end
            if (mem_req_ready) mem_req_ready = 1'b0;
            else if (mem_req_valid) begin
               mem_req_ready = 1'b1;
               log_q.push_back('{mem_req_rnw, mem_req_addr, mem_req_wdata, mem_req_wmask});
               if (mem_req_rnw) begin
                  ra = mem_req_addr;
                  dly = 3;
               end else mem_write(mem_req_addr, mem_req_wdata, mem_req_wmask);
            end
         end
      end
   end

   task automatic op(input string tag, input logic dre, input logic [3:0] dwe, input logic [31:0] da,
                     input logic [31:0] dd, input logic ire, input logic [31:0] ia, output int n);
      dcache_re = dre;
      dcache_we = dwe;
      dcache_addr = da;
      dcache_din = dd;
      icache_re = ire;
      icache_addr = ia;
      @(negedge cpu_clk_g);
      n = 0;
      while (stall && n < 100) begin
         @(negedge cpu_clk_g);
         n++;
      end
      if (stall) check({tag, "_timeout"}, 32'd1, 32'd0);
      dcache_re = 1'b0;
      dcache_we = 4'h0;
      icache_re = 1'b0;
   endtask

   task automatic d_wr(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
      int n, n0;
      n0 = log_q.size();
      op(tag, 1'b0, we, a, d, 1'b0, 32'h0, n);
      check({tag, "_nreq"}, 32'(log_q.size() - n0), 32'd1);
      check({tag, "_stalled"}, 32'(n > 0), 32'd1);
      if (log_q.size() > n0) begin
         check({tag, "_rnw"}, 32'(log_q[n0].rnw), 32'd0);
         check({tag, "_addr"}, log_q[n0].addr, {a[31:2], 2'b00});
         check({tag, "_wdata"}, log_q[n0].wdata, d);
         check({tag, "_wmask"}, 32'(log_q[n0].wmask), 32'(we));
      end
   endtask

   task automatic d_rd(input string tag, input logic [31:0] a, input logic [31:0] exp, input logic miss);
      int n, n0;
      n0 = log_q.size();
      op(tag, 1'b1, 4'h0, a, 32'h0, 1'b0, 32'h0, n);
      check({tag, "_dout"}, dcache_dout, exp);
      if (miss) begin
         exp_miss++;
         check({tag, "_nreq"}, 32'(log_q.size() - n0), 32'd1);
         if (log_q.size() > n0) begin
            check({tag, "_rnw"}, 32'(log_q[n0].rnw), 32'd1);
            check({tag, "_addr"}, log_q[n0].addr, {a[31:4], 4'h0});
         end
      end else begin
         exp_hit++;
         check({tag, "_nreq"}, 32'(log_q.size() - n0), 32'd0);
         check({tag, "_stall_cycles"}, 32'(n), 32'd0);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      int n, n0;
      dcache_addr = '0;
      dcache_re = 1'b0;
      dcache_we = 4'h0;
      dcache_din = '0;
      icache_addr = '0;
      icache_re = 1'b0;
      icache_we = 4'h0;
      icache_din = '0;
      mem[32'h0020_0010] = 32'hCAFE_F00D;
      mem[32'h0000_3004] = 32'h00A0_0093;
      repeat (3) @(negedge cpu_clk_g);
      check("rst_init_done", 32'(init_done), 32'd0);
      check("rst_stall", 32'(stall), 32'd1);
      check("rst_req_valid", 32'(mem_req_valid), 32'd0);
      check("rst_dout", dcache_dout, 32'h0);
      check("rst_instr", instruction, 32'h0);
`ifdef CACHE_STATS_EN
      check("rst_hit_cnt", dcache_hit_cnt, 32'd0);
      check("rst_miss_cnt", dcache_miss_cnt, 32'd0);
`endif
      rst_n = 1'b1;
      repeat (255) @(negedge cpu_clk_g);
      check("init_255_done", 32'(init_done), 32'd0);
      check("init_255_stall", 32'(stall), 32'd1);
      @(negedge cpu_clk_g);
      check("init_256_done", 32'(init_done), 32'd1);
      @(negedge cpu_clk_g);
      check("init_257_stall", 32'(stall), 32'd0);

      d_wr("w0", 32'h0000_0000, 32'h1234_5678, 4'hF);
      d_rd("r0_miss", 32'h0000_0000, 32'h1234_5678, 1'b1);
      d_rd("r0_hit", 32'h0000_0000, 32'h1234_5678, 1'b0);
      d_wr("w1", 32'h0000_0000, 32'hDEAD_BEEF, 4'hF);
      d_rd("r1_hit", 32'h0000_0000, 32'hDEAD_BEEF, 1'b0);
      d_wr("w2", 32'h0000_0000, 32'h1234_5678, 4'hF);
      d_rd("r2_hit", 32'h0000_0000, 32'h1234_5678, 1'b0);
      d_wr("w3_noalloc", 32'h0010_0000, 32'h1234_4321, 4'hF);
      d_rd("r3_miss", 32'h0010_0000, 32'h1234_4321, 1'b1);
      d_rd("r4_evicted", 32'h0000_0000, 32'h1234_5678, 1'b1);
      d_wr("wb_byte", 32'h0000_0000, 32'h0000_AB00, 4'b0010);
      d_rd("rb_hit", 32'h0000_0000, 32'h1234_AB78, 1'b0);

      n0 = log_q.size();
      op("dual", 1'b1, 4'h0, 32'h0020_0010, 32'h0, 1'b1, 32'h0000_3004, n);
      exp_miss++;
      check("dual_nreq", 32'(log_q.size() - n0), 32'd2);
      if (log_q.size() >= n0 + 2) begin
         check("dual_first_addr", log_q[n0].addr, 32'h0020_0010);
         check("dual_first_rnw", 32'(log_q[n0].rnw), 32'd1);
         check("dual_second_addr", log_q[n0+1].addr, 32'h0000_3000);
         check("dual_second_rnw", 32'(log_q[n0+1].rnw), 32'd1);
      end
      check("dual_stalled", 32'(n >= 8), 32'd1);
      check("dual_dout", dcache_dout, 32'hCAFE_F00D);
      check("dual_instr", instruction, 32'h00A0_0093);

      n0 = log_q.size();
      op("both_hit", 1'b1, 4'h0, 32'h0020_0010, 32'h0, 1'b1, 32'h0000_3004, n);
      exp_hit++;
      check("both_hit_nreq", 32'(log_q.size() - n0), 32'd0);
      check("both_hit_stall_cycles", 32'(n), 32'd0);
      check("both_hit_dout", dcache_dout, 32'hCAFE_F00D);
      check("both_hit_instr", instruction, 32'h00A0_0093);
      @(negedge cpu_clk_g);
      check("hold_dout", dcache_dout, 32'hCAFE_F00D);
      check("hold_instr", instruction, 32'h00A0_0093);
`ifdef CACHE_STATS_EN
      check("stats_hits", dcache_hit_cnt, 32'(exp_hit));
      check("stats_misses", dcache_miss_cnt, 32'(exp_miss));
`endif

      dcache_re = 1'b1;
      dcache_addr = 32'h0030_0000;
      repeat (3) @(negedge cpu_clk_g);
      #1 rst_n = 1'b0;
      #1;
      check("midrst_init_done", 32'(init_done), 32'd0);
      check("midrst_stall", 32'(stall), 32'd1);
      check("midrst_req_valid", 32'(mem_req_valid), 32'd0);
      check("midrst_dout", dcache_dout, 32'h0);
      dcache_re = 1'b0;
      repeat (2) @(negedge cpu_clk_g);
      rst_n = 1'b1;
      repeat (256) @(negedge cpu_clk_g);
      check("reinit_done", 32'(init_done), 32'd1);
      @(negedge cpu_clk_g);
      d_rd("after_rst_miss", 32'h0000_0000, 32'h1234_AB78, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/mem150_cache_subsystem.md
Name: mem150_cache_subsystem

Overview:
- CPU-side memory block: one direct-mapped, write-through, no-write-allocate data cache (D$) and one instruction cache (I$), both filled from a single shared line-wide memory port.
- Sits between the CPU pipeline (one global `stall` output) and the memory controller.
- Replaces the DDR2 path with a simple valid/ready request/response port.

Parameters:
- INDEX_BITS, 8, log2 lines per cache (256 lines × 16 B = 4 KB each).
- LINE_WORDS, 4, 32-bit words per line (fixed at 4; fill data 128 bits).

Ports:
- cpu_clk_g  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- init_done  out  1  high once valid-bit clear completes.
- dcache_addr  in  32  D$ byte address; bits [1:0] ignored.
- dcache_re  in  1  D$ read request.
- dcache_we  in  4  D$ byte write enables; bit i = byte lane i.
- dcache_din  in  32  D$ write data.
- dcache_dout  out  32  D$ read data.
- icache_addr  in  32  I$ address (PC).
- icache_re  in  1  I$ read request.
- icache_we  in  4  I$ byte write enables (instruction load path).
- icache_din  in  32  I$ write data.
- instruction  out  32  I$ read data.
- stall  out  1  CPU must hold all inputs while high.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_req_rnw  out  1  1 = line read, 0 = word write.
- mem_req_addr  out  32  read: line-aligned; write: word-aligned.
- mem_req_wdata  out  32  write data.
- mem_req_wmask  out  4  write byte mask.
- mem_resp_valid  in  1  fill data valid (one beat).
- mem_resp_data  in  128  fill line; word k at [32k+31:32k].

Behaviour:
- Address split: offset [3:2], index [INDEX_BITS+3:4], tag [31:INDEX_BITS+4].
- Each line holds valid, tag, 4 data words.

Reset:
- Reset clears all state.
- Outputs: init_done=0, stall=1, mem_req_valid=0, dcache_dout=0, instruction=0.

INIT state:
- Clears one valid bit per cycle in both caches, 2^INDEX_BITS cycles.
- Then init_done=1 permanently and the FSM enters IDLE.

Request acceptance:
- Requests are sampled at the rising edge when stall=0. re and |we together on one cache: the write takes precedence.

Hit, read:
- Tag compare occurs in the cycle after sampling; data drives dout that cycle with stall=0.
- Back-to-back hits sustain one per cycle.

Miss, read:
- stall goes high combinationally in the compare cycle.
- FILL: mem_req_valid=1, rnw=1, addr={addr[31:4],4'b0}, held until mem_req_ready.
- Then wait for mem_resp_valid and write the line with valid=1 and the new tag, evicting the old line (no writeback).
- Requested word goes to dout; stall drops the following cycle.

Write, write-through:
- Hit: merge bytes per we into the line.
- Miss: cache unchanged (no allocate).
- Always issue one memory word write: rnw=0, addr={addr[31:2],2'b0}, wdata=din, wmask=we.
- stall high until mem_req_ready is seen; the line merge completes on that edge.

Arbitration:
- D$ and I$ share the port; one outstanding memory transaction at a time.
- D$ is served first when both need memory; I$ waits with stall high.

Port rules:
- mem_req_* fields are stable while mem_req_valid=1 and ready=0.
- mem_resp_valid arriving outside FILL is ignored.

Output holds:
- dcache_dout and instruction hold their last value when no read is in progress.

Reset mid-operation:
- Any in-flight transaction is abandoned immediately and INIT restarts.

Optional Feature:
- Macro CACHE_STATS_EN.
- Defined:
  - Adds outputs dcache_hit_cnt[31:0] and dcache_miss_cnt[31:0].
  - Each counts accepted D$ reads (hit or miss) once, saturating at 32'hFFFFFFFF; cleared by reset.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Reset, release: init_done rises exactly 256 cycles after rst_n deassert; stall=1 until then, 0 one cycle later.
- Write 0x00000000←0x12345678 (we=1111) → one mem write, wmask 1111. Read 0x0 → miss, one line read at 0x0, dout 0x12345678. Read again → hit, no memory traffic, stall never high.
- Write 0x0←0xDEADBEEF → hit update plus memory write; read → hit 0xDEADBEEF. Rewrite 0x12345678, read → hit 0x12345678.
- Write 0x00100000←0x12344321 → memory write only; read 0x00100000 → miss, fill, 0x12344321.
- Read 0x0 → miss (evicted), fill returns 0x12345678 from memory.
- Byte write we=0010, din=0x0000AB00 onto hit 0x12345678 → read 0x1234AB78.
- Simultaneous D$ miss and I$ miss → D$ fill request first, then I$; both correct, stall high throughout.
- With CACHE_STATS_EN: the sequence above → hit/miss counts match the expected hits and misses exactly.
